// File: rtl/mem_scan_reader_pkg.sv
// Shared types and widths for the memory scan reader.
package mem_scan_pkg;
   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} scan_state_t;

   // Big-endian byte select: index 0 is the most significant byte.
   function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                   input logic [1:0] idx);
      logic [BYTE_W-1:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction
endpackage

// File: rtl/mem_scan_reader_if.sv
// Video-port read bus plus byte stream handshake of the scan reader.
interface mem_scan_reader_if;
   import mem_scan_pkg::*;
   logic [WORD_W-1:0] va;
   logic [WORD_W-1:0] vd;
   logic [BYTE_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output va, output out_data, output out_valid,
                   input vd, input out_ready);
   modport slave  (input va, input out_data, input out_valid,
                   output vd, output out_ready);
endinterface

// File: rtl/mem_scan_reader_word_fifo.sv
// Small word FIFO; 1-cycle write-to-read, dout is the head word whenever not empty.
module word_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO is only taken when the head leaves on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/mem_scan_reader.sv
// Scans NUM_WORDS words from BASE_WORD and streams them big-endian as bytes; first byte 2 cycles after start.
// Fetch stalls while the FIFO is full; SCAN_CHECKSUM_EN appends a 4-byte sum of all words.
module mem_scan_reader
   import mem_scan_pkg::*;
#(
   parameter int BASE_WORD  = 0,
   parameter int NUM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   mem_scan_reader_if.master  bus
);
   localparam int            IDX_W = 7;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   scan_state_t       state, state_nxt;
   logic [IDX_W-1:0]  idx;
   logic              push, pop, full, empty;
   logic [WORD_W-1:0] head;
   logic [WORD_W-1:0] ser_word;
   logic [1:0]        ser_cnt;
   logic              ser_vld;
   logic              take, ser_free, trl_load, tail_done, scan_end;
   logic [WORD_W-1:0] load_word;

   word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (bus.vd),
      .dout    (head),
      .full    (full),
      .empty   (empty)
   );

   assign bus.va = (WORD_W'(BASE_WORD) + WORD_W'(idx)) << 2;

   // The serializer may take a new word on the same edge its 4th byte leaves.
   assign take     = ser_vld && bus.out_ready;
   assign ser_free = !ser_vld || (take && (ser_cnt == 2'd3));
   assign pop      = ser_free && !empty;

`ifdef SCAN_CHECKSUM_EN
   logic [WORD_W-1:0] csum;
   logic              trl_sent;

   assign trl_load  = ser_free && empty && (state == DRAIN) && !trl_sent;
   assign tail_done = trl_sent;
   assign load_word = pop ? head : csum;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         csum     <= '0;
         trl_sent <= 1'b0;
      end else if ((state == IDLE) && start) begin
         csum     <= '0;
         trl_sent <= 1'b0;
      end else begin
         if (push)     csum     <= csum + bus.vd;
         if (trl_load) trl_sent <= 1'b1;
      end
   end
`else
   assign trl_load  = 1'b0;
   assign tail_done = 1'b1;
   assign load_word = head;
`endif

   assign scan_end      = (state == DRAIN) && empty && !ser_vld && tail_done;
   assign done          = scan_end;
   assign busy          = (state != IDLE);
   assign bus.out_valid = ser_vld;
   assign bus.out_data  = word_byte(ser_word, ser_cnt);

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: if (!full) begin
                   push = 1'b1;
                   if (idx == LAST_IDX) state_nxt = DRAIN;
                end
         DRAIN: if (scan_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         idx      <= '0;
         ser_vld  <= 1'b0;
         ser_cnt  <= '0;
         ser_word <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && start) idx <= '0;
         else if (push)                idx <= idx + 1'b1;

         if (pop || trl_load) begin
            ser_word <= load_word;
            ser_cnt  <= '0;
            ser_vld  <= 1'b1;
         end else if (take) begin
            ser_cnt <= ser_cnt + 1'b1;
            if (ser_cnt == 2'd3) ser_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_scan_reader.sv
// Three reader configurations checked against a byte-queue model of each scan.
module tb_mem_scan_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  st, rdy;
   logic [31:0] mem [64];

   mem_scan_reader_if b0 ();
   mem_scan_reader_if b1 ();
   mem_scan_reader_if b2 ();

   assign b0.vd = mem[b0.va[7:2]];
   assign b1.vd = mem[b1.va[7:2]];
   assign b2.vd = mem[b2.va[7:2]];
   assign b0.out_ready = rdy[0];
   assign b1.out_ready = rdy[1];
   assign b2.out_ready = rdy[2];

   logic [31:0] va_a [3];
   logic [7:0]  od [3];
   logic [2:0]  ov, bz, dn;
   assign va_a[0] = b0.va;  assign od[0] = b0.out_data;  assign ov[0] = b0.out_valid;
   assign va_a[1] = b1.va;  assign od[1] = b1.out_data;  assign ov[1] = b1.out_valid;
   assign va_a[2] = b2.va;  assign od[2] = b2.out_data;  assign ov[2] = b2.out_valid;

   mem_scan_reader #(.BASE_WORD(0),  .NUM_WORDS(4),  .FIFO_DEPTH(4)) u0 (
      .clk(clk), .reset_n(rst_n), .start(st[0]), .busy(bz[0]), .done(dn[0]), .bus(b0));
   mem_scan_reader #(.BASE_WORD(62), .NUM_WORDS(2),  .FIFO_DEPTH(2)) u1 (
      .clk(clk), .reset_n(rst_n), .start(st[1]), .busy(bz[1]), .done(dn[1]), .bus(b1));
   mem_scan_reader #(.BASE_WORD(4),  .NUM_WORDS(16), .FIFO_DEPTH(2)) u2 (
      .clk(clk), .reset_n(rst_n), .start(st[2]), .busy(bz[2]), .done(dn[2]), .bus(b2));

   int base_w [3] = '{0, 62, 4};
   int num_w  [3] = '{4, 2, 16};
`ifdef SCAN_CHECKSUM_EN
   localparam int TRL = 4;
`else
   localparam int TRL = 0;
`endif

   int checks = 0;
   int failures = 0;

   // Model state: expected byte list of the current scan, plus busy/done expectation.
   logic [7:0] exp_b [3][128];
   int         exp_len [3] = '{0, 0, 0};
   int         exp_pos [3] = '{0, 0, 0};
   logic       m_busy [3] = '{1'b0, 1'b0, 1'b0};
   logic       m_done [3] = '{1'b0, 1'b0, 1'b0};
   logic       hold_v [3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0] hold_d [3];
   logic [7:0] log_b [3][4096];
   int         log_n [3] = '{0, 0, 0};
   int         dn_cnt [3] = '{0, 0, 0};

   logic [7:0] lit [20] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                            8'hBB, 8'hDE, 8'h00, 8'h20};

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d actual=%0h required=%0h", nm, i, act, exp);
      end
   endtask

   task automatic build(input int i);
      logic [31:0] w, sum;
      sum = 0;
      exp_len[i] = 0;
      exp_pos[i] = 0;
      for (int k = 0; k < num_w[i]; k++) begin
         w = mem[base_w[i] + k];
         sum = sum + w;
         for (int b = 3; b >= 0; b--) begin
            exp_b[i][exp_len[i]] = w[b*8 +: 8];
            exp_len[i]++;
         end
      end
      if (TRL != 0) begin
         for (int b = 3; b >= 0; b--) begin
            exp_b[i][exp_len[i]] = sum[b*8 +: 8];
            exp_len[i]++;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic take, last, pend;
         last = 1'b0;
         chk("busy", i, 32'(bz[i]), 32'(m_busy[i]));
         chk("done", i, 32'(dn[i]), 32'(m_done[i]));
         chk("va_align", i, 32'(va_a[i][1:0]), 32'd0);
         if (m_busy[i])
            chk("va_window", i, 32'(va_a[i] >= 32'(base_w[i]*4) &&
                                   va_a[i] <= 32'((base_w[i]+num_w[i])*4)), 32'd1);
         if (hold_v[i]) begin
            chk("valid_held", i, 32'(ov[i]), 32'd1);
            chk("data_stable", i, 32'(od[i]), 32'(hold_d[i]));
         end
         take = ov[i] && rdy[i];
         pend = exp_pos[i] < exp_len[i];
         if (ov[i] && !pend) begin
            chk("valid_pending", i, 32'(ov[i]), 32'(pend));
         end else if (take) begin
            chk("byte", i, 32'(od[i]), 32'(exp_b[i][exp_pos[i]]));
            if (log_n[i] < 4096) log_b[i][log_n[i]] = od[i];
            log_n[i]++;
            exp_pos[i]++;
            last = (exp_pos[i] == exp_len[i]);
         end
         hold_v[i] = ov[i] && !rdy[i];
         hold_d[i] = od[i];
         if (dn[i]) dn_cnt[i]++;
         if (!rst_n) begin
            m_busy[i] = 1'b0;  m_done[i] = 1'b0;  hold_v[i] = 1'b0;
            exp_pos[i] = 0;    exp_len[i] = 0;
         end else if (m_done[i]) begin
            m_busy[i] = 1'b0;  m_done[i] = 1'b0;
         end else if (st[i] && !m_busy[i]) begin
            m_busy[i] = 1'b1;
            build(i);
         end else if (last) begin
            m_done[i] = 1'b1;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int i);
      st[i] = 1'b1;
      cyc(1);
      st[i] = 1'b0;
   endtask

   // mode 0: always ready, 1: ready one cycle in three, 2: random ready
   task automatic run_idle(input int i, input int mode);
      for (int k = 0; k < 3000 && m_busy[i]; k++) begin
         rdy[i] = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'(($urandom & 1));
         cyc(1);
      end
      chk("busy_after_scan", i, 32'(bz[i]), 32'd0);
   endtask

   task automatic cmp_lit(input int i, input int from, input int n);
      for (int k = 0; k < n; k++) chk("seq_byte", i, 32'(log_b[i][from + k]), 32'(lit[k]));
   endtask

   initial begin
      int l0, d0, nexp;
      rst_n = 1'b0; st = '0; rdy = '0;
      for (int w = 0; w < 64; w++) mem[w] = 32'(w) * 32'h01010101;
      mem[0] = 32'h11223344; mem[1] = 32'hAABBCCDD; mem[2] = 32'h0; mem[3] = 32'hFFFFFFFF;
      nexp = 16 + TRL;
      cyc(3);
      chk("rst_va", 0, va_a[0], 32'h0);
      chk("rst_va", 1, va_a[1], 32'hF8);
      chk("rst_va", 2, va_a[2], 32'h10);
      chk("rst_valid", 0, 32'(ov), 32'd0);
      chk("rst_data", 0, 32'(od[0]), 32'd0);
      chk("rst_busy", 0, 32'(bz), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Full-rate scan with first-byte latency
      rdy[0] = 1'b1; l0 = log_n[0]; d0 = dn_cnt[0];
      st[0] = 1'b1; cyc(1); st[0] = 1'b0;
      cyc(1);
      chk("latency_not_yet", 0, 32'(ov[0]), 32'd0);
      cyc(1);
      chk("latency_valid", 0, 32'(ov[0]), 32'd1);
      chk("first_byte", 0, 32'(od[0]), 32'h11);
      run_idle(0, 0);
      cmp_lit(0, l0, nexp);
      chk("byte_count", 0, 32'(log_n[0] - l0), 32'(nexp));
      chk("done_count", 0, 32'(dn_cnt[0] - d0), 32'd1);

      // Backpressure: fetch finishes while the sink holds off
      rdy[0] = 1'b0; l0 = log_n[0]; d0 = dn_cnt[0];
      pulse_start(0);
      cyc(8);
      chk("va_drain_hold", 0, va_a[0], 32'h10);
      chk("bp_valid", 0, 32'(ov[0]), 32'd1);
      chk("bp_data", 0, 32'(od[0]), 32'h11);
      run_idle(0, 1);
      cmp_lit(0, l0, nexp);
      chk("done_count_bp", 0, 32'(dn_cnt[0] - d0), 32'd1);

      // FIFO-full stall on the long, shallow instance
      rdy[2] = 1'b0;
      pulse_start(2);
      cyc(6);
      chk("va_stall", 2, va_a[2], 32'h1C);
      cyc(4);
      chk("va_stall_held", 2, va_a[2], 32'h1C);
      run_idle(2, 2);

      // Top-of-memory window, two back-to-back scans
      rdy[1] = 1'b1; l0 = log_n[1];
      pulse_start(1);
      chk("va_win0", 1, va_a[1], 32'hF8);
      cyc(1);
      chk("va_win1", 1, va_a[1], 32'hFC);
      run_idle(1, 0);
      chk("win_bytes", 1, 32'(log_n[1] - l0), 32'(8 + TRL));
      l0 = log_n[1];
      pulse_start(1);
      run_idle(1, 1);
      chk("win_bytes2", 1, 32'(log_n[1] - l0), 32'(8 + TRL));

      // start pulses while busy are ignored
      l0 = log_n[0]; d0 = dn_cnt[0];
      pulse_start(0);
      for (int k = 0; k < 3000 && m_busy[0]; k++) begin
         st[0] = (k % 5 == 2);
         rdy[0] = (k % 3 == 0);
         cyc(1);
      end
      st[0] = 1'b0;
      chk("restart_bytes", 0, 32'(log_n[0] - l0), 32'(nexp));
      chk("restart_done", 0, 32'(dn_cnt[0] - d0), 32'd1);

      // Reset after five bytes aborts; next scan starts from word 0
      rdy[0] = 1'b1; l0 = log_n[0];
      pulse_start(0);
      for (int k = 0; k < 100 && log_n[0] < l0 + 5; k++) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("abort_valid", 0, 32'(ov[0]), 32'd0);
      chk("abort_busy", 0, 32'(bz[0]), 32'd0);
      chk("abort_va", 0, va_a[0], 32'h0);
      l0 = log_n[0];
      pulse_start(0);
      run_idle(0, 0);
      cmp_lit(0, l0, nexp);

`ifdef SCAN_CHECKSUM_EN
      mem[0] = 32'h1; mem[1] = 32'hFFFFFFFF; mem[2] = 32'h10; mem[3] = 32'h0;
      l0 = log_n[0];
      pulse_start(0);
      run_idle(0, 1);
      chk("cs_len", 0, 32'(log_n[0] - l0), 32'd20);
      chk("cs_b0", 0, 32'(log_b[0][l0 + 16]), 32'h00);
      chk("cs_b2", 0, 32'(log_b[0][l0 + 18]), 32'h00);
      chk("cs_b3", 0, 32'(log_b[0][l0 + 19]), 32'h10);
`endif

      // Randomized rounds: random memory, starts, backpressure and occasional reset
      for (int r = 0; r < 25; r++) begin
         for (int w = 0; w < 64; w++) mem[w] = $urandom;
         for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 3; i++) begin
               st[i]  = ($urandom_range(0, 9) == 0);
               rdy[i] = ($urandom_range(0, 3) != 0);
            end
            rst_n = !((r % 8 == 7) && (k == 150));
            cyc(1);
         end
         st = '0; rdy = 3'b111; rst_n = 1'b1;
         for (int k = 0; k < 2000 && (m_busy[0] || m_busy[1] || m_busy[2]); k++) cyc(1);
         for (int i = 0; i < 3; i++) chk("rand_idle", i, 32'(bz[i]), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
